// File: rtl/adder16_arbiter_pkg.sv
// Shared definitions for the adder16_arbiter slice.
//  - ADDER_W : datapath width of the shared adder
//  - state_t : transaction FSM encoding (IDLE -> EXEC -> RESP -> IDLE)
package adder16_arbiter_pkg;

  localparam int ADDER_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/adder16_arbiter_adder.sv
// Ripple-carry adder used as the single shared datapath.
// Ports:
//  a, b  in   W  operands
//  sum   out  W  (a+b) mod 2^W
//  cout  out  1  carry out of the top bit
module ripple_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] carry_s;

  assign carry_s[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry_s[i];
    assign carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
  end

  assign cout = carry_s[W];

endmodule

// File: rtl/adder16_arbiter_rr_arbiter.sv
// Purely combinational round-robin arbiter.
// Ports:
//  req       in   NUM_REQ  request vector
//  rr_ptr    in   ID_W     index with highest priority this round
//  grant_oh  out  NUM_REQ  one-hot grant (all zero when no request)
//  grant_idx out  ID_W     index of the granted requester
//  any_req   out  1        at least one request is present
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_req
);

  logic            found_s;
  logic [ID_W-1:0] idx_s;

  // Search upward from rr_ptr with wrap; the first set request wins.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found_s   = 1'b0;
    idx_s     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found_s && req[idx_s]) begin
        found_s         = 1'b1;
        grant_idx       = idx_s;
        grant_oh[idx_s] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/adder16_arbiter.sv
// Shares one 16-bit ripple adder among NUM_REQ requesters.
// A round-robin grant accepts one operand pair in IDLE, the adder runs from the
// operand registers in EXEC, and the tagged result is held in RESP until taken.
// Ports:
//  clk        in   1            rising-edge clock
//  rst_n      in   1            synchronous reset, active low
//  req_valid  in   NUM_REQ      requester i has an operand pair
//  req_ready  out  NUM_REQ      one-hot accept strobe (combinational, IDLE only)
//  req_a      in   16*NUM_REQ   operand A, requester i at [16*i+15:16*i]
//  req_b      in   16*NUM_REQ   operand B, same packing
//  rsp_valid  out  1            result available
//  rsp_ready  in   1            consumer takes result
//  rsp_id     out  ID_W         index of the served requester
//  rsp_sum    out  16           (a+b) mod 2^16
//  rsp_cout   out  1            carry out of bit 15
module adder16_arbiter
  import adder16_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [ADDER_W*NUM_REQ-1:0] req_a,
  input  logic [ADDER_W*NUM_REQ-1:0] req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [ADDER_W-1:0]         rsp_sum,
  output logic                       rsp_cout
);

  state_t               state_r;
  state_t               state_next_s;
  logic [ID_W-1:0]      rr_ptr_r;
  logic [ID_W-1:0]      rr_ptr_next_s;
  logic [ID_W-1:0]      grant_r;
  logic [ADDER_W-1:0]   op_a_r;
  logic [ADDER_W-1:0]   op_b_r;
  logic                 rsp_valid_r;
  logic [ID_W-1:0]      rsp_id_r;
  logic [ADDER_W-1:0]   rsp_sum_r;
  logic                 rsp_cout_r;

  logic [NUM_REQ-1:0]   arb_oh_s;
  logic [ID_W-1:0]      arb_idx_s;
  logic                 any_req_s;
  logic                 accept_s;
  logic [ADDER_W-1:0]   add_sum_s;
  logic                 add_cout_s;
  logic [ADDER_W-1:0]   a_slice_s [NUM_REQ];
  logic [ADDER_W-1:0]   b_slice_s [NUM_REQ];

  // Unpack the flat operand buses into per-requester words.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign a_slice_s[i] = req_a[ADDER_W*i +: ADDER_W];
    assign b_slice_s[i] = req_b[ADDER_W*i +: ADDER_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_r),
    .grant_oh  (arb_oh_s),
    .grant_idx (arb_idx_s),
    .any_req   (any_req_s)
  );

  // The adder sees only the operand registers, never the request ports.
  ripple_adder #(
    .W (ADDER_W)
  ) u_add (
    .a    (op_a_r),
    .b    (op_b_r),
    .sum  (add_sum_s),
    .cout (add_cout_s)
  );

  // Accept only in IDLE and never while reset is held.
  assign accept_s = (state_r == ST_IDLE) && any_req_s && rst_n;

  // Served requester drops to lowest priority; non-power-of-two counts wrap explicitly.
  assign rr_ptr_next_s = (grant_r == ID_W'(NUM_REQ - 1)) ? '0 : grant_r + ID_W'(1);

  // Accept strobe for the granted requester.
  always_comb begin
    req_ready = '0;
    if (accept_s) begin
      req_ready = arb_oh_s;
    end else begin
      req_ready = '0;
    end
  end

  // Next-state logic for the transaction FSM.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_next_s = ST_EXEC;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        state_next_s = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand capture, result registers and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_r    <= '0;
      grant_r     <= '0;
      op_a_r      <= '0;
      op_b_r      <= '0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= '0;
      rsp_sum_r   <= '0;
      rsp_cout_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            op_a_r  <= a_slice_s[arb_idx_s];
            op_b_r  <= b_slice_s[arb_idx_s];
            grant_r <= arb_idx_s;
          end
        end
        ST_EXEC: begin
          rsp_sum_r   <= add_sum_s;
          rsp_cout_r  <= add_cout_s;
          rsp_id_r    <= grant_r;
          rsp_valid_r <= 1'b1;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            rr_ptr_r    <= rr_ptr_next_s;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_sum   = rsp_sum_r;
  assign rsp_cout  = rsp_cout_r;

endmodule

// File: tb/tb_adder16_arbiter.sv
// Self-checking bench for adder16_arbiter (NUM_REQ=4).
// Directed sequences, a table of single transactions, then randomized traffic
// checked against a transaction-level model.
module tb_adder16_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [16*N-1:0] req_a;
  logic [16*N-1:0] req_b;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic [15:0]   rsp_sum;
  logic          rsp_cout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  adder16_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
  );

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    logic        cout;
  } vec_t;

  vec_t        vt [6];
  logic [15:0] ta [N];
  logic [15:0] tb [N];
  int          gs [7];

  // random-phase model state
  bit          pend [N];
  logic [15:0] ra [N];
  logic [15:0] rb [N];
  int          ptr;
  bit          busy;
  int          g;
  int          acc;
  logic [16:0] exp_full;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic run_single(input int id, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] es, input logic ec);
    int waited;
    logic [31:0] oh;
    oh = 32'd1 << id;
    req_a[16*id +: 16] = a;
    req_b[16*id +: 16] = b;
    req_valid = 4'(oh);
    rsp_ready = 1'b1;
    waited = 0;
    smp();
    while (req_ready == 4'd0 && waited < 8) begin
      adv();
      smp();
      waited++;
    end
    check("single_ready", req_ready, oh);
    adv();
    req_valid = 4'd0;
    smp();
    check("single_lat_t1", rsp_valid, 1'b0);
    adv();
    smp();
    check("single_valid_t2", rsp_valid, 1'b1);
    check("single_id", rsp_id, id);
    check("single_sum", rsp_sum, es);
    check("single_cout", rsp_cout, ec);
    adv();
  endtask

  initial begin
    logic [16:0] s;
    int phase;
    int slot;
    bit found;

    vt[0] = '{id: 1, a: 16'h1234, b: 16'h0FED, sum: 16'h2221, cout: 1'b0};
    vt[1] = '{id: 2, a: 16'hFFFF, b: 16'h0001, sum: 16'h0000, cout: 1'b1};
    vt[2] = '{id: 3, a: 16'h8000, b: 16'h8000, sum: 16'h0000, cout: 1'b1};
    vt[3] = '{id: 3, a: 16'hFFFF, b: 16'hFFFF, sum: 16'hFFFE, cout: 1'b1};
    vt[4] = '{id: 2, a: 16'h00FF, b: 16'h0F01, sum: 16'h1000, cout: 1'b0};
    vt[5] = '{id: 0, a: 16'h0000, b: 16'h0000, sum: 16'h0000, cout: 1'b0};
    ta = '{16'h1111, 16'h2222, 16'h3333, 16'hF444};
    tb = '{16'h0F0F, 16'h0F10, 16'h0F11, 16'h0F12};
    gs = '{0, 1, 2, 3, 0, 2, 0};

    // Reset with every requester asking
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    adv();
    for (int i = 0; i < 2; i++) begin
      smp();
      check("rst_ready", req_ready, 4'd0);
      check("rst_valid", rsp_valid, 1'b0);
      check("rst_sum", rsp_sum, 16'd0);
      adv();
    end

    // Round robin: all four, then only 0 and 2 after 3 is served
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_a[16*i +: 16] = ta[i];
      req_b[16*i +: 16] = tb[i];
    end
    for (int c = 0; c < 21; c++) begin
      if (c >= 19) req_valid = 4'h0;
      else if (c >= 10) req_valid = 4'b0101;
      else req_valid = 4'hF;
      smp();
      slot  = c / 3;
      phase = c % 3;
      check("rr_ready", req_ready, (phase == 0) ? (32'd1 << gs[slot]) : 32'd0);
      check("rr_valid", rsp_valid, (phase == 2) ? 1'b1 : 1'b0);
      if (phase == 2) begin
        s = {1'b0, ta[gs[slot]]} + {1'b0, tb[gs[slot]]};
        check("rr_id", rsp_id, gs[slot]);
        check("rr_sum", rsp_sum, s[15:0]);
        check("rr_cout", rsp_cout, s[16]);
      end
      adv();
    end

    // Table of single transactions
    for (int i = 0; i < 6; i++) begin
      run_single(vt[i].id, vt[i].a, vt[i].b, vt[i].sum, vt[i].cout);
    end

    // Backpressure in RESP
    req_a[16 +: 16] = 16'hABCD;
    req_b[16 +: 16] = 16'h1234;
    req_a[32 +: 16] = 16'h3333;
    req_b[32 +: 16] = 16'h0F11;
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    smp();
    check("bp_accept", req_ready, 4'b0010);
    adv();
    req_valid = 4'hF;
    smp();
    check("bp_exec_ready", req_ready, 4'd0);
    adv();
    for (int k = 0; k < 5; k++) begin
      smp();
      check("bp_valid", rsp_valid, 1'b1);
      check("bp_sum", rsp_sum, 16'hBE01);
      check("bp_id", rsp_id, 2'd1);
      check("bp_cout", rsp_cout, 1'b0);
      check("bp_ready", req_ready, 4'd0);
      adv();
    end
    rsp_ready = 1'b1;
    smp();
    check("bp_hs_valid", rsp_valid, 1'b1);
    check("bp_hs_ready", req_ready, 4'd0);
    adv();
    smp();
    check("bp_next_grant", req_ready, 4'b0100);
    adv();
    req_valid = 4'd0;
    smp();
    check("bp_next_t1", rsp_valid, 1'b0);
    adv();
    smp();
    check("bp_next_id", rsp_id, 2'd2);
    check("bp_next_sum", rsp_sum, 16'h4244);
    adv();

    // Reset during EXEC
    req_valid = 4'b1000;
    smp();
    check("mid_accept", req_ready, 4'b1000);
    adv();
    req_valid = 4'd0;
    rst_n = 1'b0;
    smp();
    check("mid_rst_ready", req_ready, 4'd0);
    adv();
    rst_n = 1'b1;
    smp();
    check("mid_exec_noresp", rsp_valid, 1'b0);
    adv();
    req_valid = 4'hF;
    smp();
    check("mid_exec_noresp2", rsp_valid, 1'b0);
    check("mid_ptr0_grant", req_ready, 4'b0001);
    adv();
    // Reset during RESP
    req_valid = 4'd0;
    rsp_ready = 1'b0;
    smp();
    check("mid2_t1", rsp_valid, 1'b0);
    adv();
    smp();
    check("mid2_resp", rsp_valid, 1'b1);
    rst_n = 1'b0;
    adv();
    rst_n = 1'b1;
    smp();
    check("mid_resp_noresp", rsp_valid, 1'b0);
    adv();
    req_valid = 4'b1100;
    rsp_ready = 1'b1;
    smp();
    check("mid_resp_noresp2", rsp_valid, 1'b0);
    check("mid2_grant", req_ready, 4'b0100);
    adv();
    req_valid = 4'd0;
    adv();
    smp();
    check("mid2_id", rsp_id, 2'd2);
    check("mid2_sum", rsp_sum, 16'h4244);
    adv();

    // Randomized traffic against the transaction model
    rst_n = 1'b0;
    req_valid = 4'd0;
    adv();
    rst_n = 1'b1;
    ptr  = 0;
    busy = 1'b0;
    acc  = 0;
    g    = 0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 30) begin
          pend[i] = 1'b1;
          ra[i] = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
          rb[i] = 16'($urandom);
        end
        req_valid[i] = pend[i];
        req_a[16*i +: 16] = ra[i];
        req_b[16*i +: 16] = rb[i];
      end
      rsp_ready = ($urandom_range(0, 99) < 60);
      smp();
      if (!busy) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          if (!found && pend[(ptr + k) % N]) begin
            found = 1'b1;
            g = (ptr + k) % N;
          end
        end
        check("rnd_ready", req_ready, found ? (32'd1 << g) : 32'd0);
        check("rnd_idle_valid", rsp_valid, 1'b0);
        if (found) begin
          busy = 1'b1;
          acc = cyc;
          exp_full = {1'b0, ra[g]} + {1'b0, rb[g]};
          pend[g] = 1'b0;
        end
      end else begin
        check("rnd_busy_ready", req_ready, 4'd0);
        check("rnd_valid", rsp_valid, (cyc >= acc + 2) ? 1'b1 : 1'b0);
        if (cyc >= acc + 2) begin
          check("rnd_id", rsp_id, g);
          check("rnd_sum", rsp_sum, exp_full[15:0]);
          check("rnd_cout", rsp_cout, exp_full[16]);
          if (rsp_ready) begin
            busy = 1'b0;
            ptr = (g + 1) % N;
          end
        end
      end
      adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
